// File: rtl/four_bit_adder_substractor.sv
// Registered 4-bit ripple adder/subtractor with selectable output format.
// cin selects the operation (0 add, 1 subtract); cout selects sign-extended or raw ripple output.
module four_bit_adder_substractor (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  input  logic       cout,
  output logic [7:0] addsub
);

  logic [3:0] b_x;
  logic [3:0] sum;
  logic [4:0] carry;
  logic       carry4;
  logic       bit4;
  logic       sign;
  logic [7:0] addsub_d;
  logic [7:0] addsub_q;

  assign b_x      = b ^ {4{cin}};
  assign carry[0] = cin;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_fa
      assign sum[gi]     = a[gi] ^ b_x[gi] ^ carry[gi];
      assign carry[gi+1] = (a[gi] & b_x[gi]) | (a[gi] & carry[gi]) | (b_x[gi] & carry[gi]);
    end
  endgenerate

  assign carry4 = carry[4];

  // For subtraction a missing carry out means a borrow, i.e. a negative result.
  assign sign = cin & ~carry4;
  assign bit4 = carry4 ^ cin;

  always_comb begin
    addsub_d = 8'h00;
    if (cout) begin
      addsub_d = {3'b000, carry4, sum};
    end else begin
      addsub_d = {{3{sign}}, bit4, sum};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addsub_q <= 8'h00;
    end else begin
      addsub_q <= addsub_d;
    end
  end

  assign addsub = addsub_q;

endmodule

// File: tb/tb_four_bit_adder_substractor.sv
// Self-checking bench: expected results queued at drive time, popped one edge later.
module tb_four_bit_adder_substractor;

  logic       clk;
  logic       rst;
  logic [3:0] a;
  logic [3:0] b;
  logic       cin;
  logic       cout;
  logic [7:0] addsub;

  int n_tests;
  int n_fail;
  logic [7:0] sb[$];
  logic [7:0] exp_v;
  logic [7:0] last_exp;

  four_bit_adder_substractor dut (
    .clk   (clk),
    .rst   (rst),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .cout  (cout),
    .addsub(addsub)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] model(input int av, input int bv, input int ci, input int co);
    int d;
    if (ci == 0) d = av + bv;
    else if (co == 0) d = av - bv;
    else d = av + 16 - bv;
    return d[7:0];
  endfunction

  // Drive one vector on the falling edge and queue its expected result.
  task automatic drive(input int av, input int bv, input int ci, input int co);
    @(negedge clk);
    a = av[3:0];
    b = bv[3:0];
    cin = ci[0];
    cout = co[0];
    sb.push_back(model(av, bv, ci, co));
  endtask

  task automatic test_reset;
    rst = 1'b1;
    a = 4'h6; b = 4'h3; cin = 1'b0; cout = 1'b0;
    #1;
    n_tests++;
    if (addsub !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_immediate: got %h expected %h", addsub, 8'h00);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_tests++;
      if (addsub !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_hold[%0d]: got %h expected %h", i, addsub, 8'h00);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    sb.push_back(model(6, 3, 0, 0));
    #1;
    n_tests++;
    if (addsub !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_release_pre_edge: got %h expected %h", addsub, 8'h00);
    end
    @(posedge clk); #1;
    exp_v = sb.pop_front();
    n_tests++;
    if (addsub !== exp_v || exp_v !== 8'h09) begin
      n_fail++;
      $display("FAIL reset_first_update: got %h expected %h", addsub, 8'h09);
    end
    $display("[TB] reset a=6 b=3 -> %h", addsub);
  endtask

  task automatic test_table(input string name, input int av, input int bv,
                            input int ci, input int co, input logic [7:0] spec_v);
    drive(av, bv, ci, co);
    @(posedge clk); #1;
    exp_v = sb.pop_front();
    n_tests++;
    if (addsub !== spec_v || exp_v !== spec_v) begin
      n_fail++;
      $display("FAIL %s a=%0d b=%0d cin=%0d cout=%0d: got %h expected %h",
               name, av, bv, ci, co, addsub, spec_v);
    end
    $display("[TB] %s a=%0d b=%0d cin=%0d cout=%0d -> %h", name, av, bv, ci, co, addsub);
  endtask

  task automatic test_add;
    test_table("add", 1, 1, 0, 0, 8'h02);
    test_table("add_max", 15, 15, 0, 0, 8'h1E);
  endtask

  task automatic test_sub;
    test_table("sub", 0, 1, 1, 0, 8'hFF);
    test_table("sub", 6, 3, 1, 0, 8'h03);
    test_table("sub", 8, 2, 1, 0, 8'h06);
    test_table("sub_min", 0, 15, 1, 0, 8'hF1);
    test_table("sub_eq", 7, 7, 1, 0, 8'h00);
  endtask

  task automatic test_raw;
    test_table("raw", 0, 1, 1, 1, 8'h0F);
    test_table("raw", 6, 3, 1, 1, 8'h13);
    test_table("raw", 9, 8, 0, 1, 8'h11);
    test_table("raw_eq", 5, 5, 1, 1, 8'h10);
  endtask

  task automatic test_back_to_back;
    int av, bv, ci, co;
    last_exp = addsub;
    for (int i = 0; i < 40; i++) begin
      av = $urandom_range(0, 15);
      bv = $urandom_range(0, 15);
      ci = $urandom_range(0, 1);
      co = $urandom_range(0, 1);
      drive(av, bv, ci, co);
      #1;
      n_tests++;
      if (addsub !== last_exp) begin
        n_fail++;
        $display("FAIL b2b_hold[%0d]: got %h expected %h", i, addsub, last_exp);
      end
      @(posedge clk); #1;
      exp_v = sb.pop_front();
      n_tests++;
      if (addsub !== exp_v) begin
        n_fail++;
        $display("FAIL b2b[%0d] a=%0d b=%0d cin=%0d cout=%0d: got %h expected %h",
                 i, av, bv, ci, co, addsub, exp_v);
      end
      $display("[TB] b2b a=%0d b=%0d cin=%0d cout=%0d -> %h", av, bv, ci, co, addsub);
      last_exp = exp_v;
    end
  endtask

  task automatic test_async_reset;
    test_table("pre_async", 9, 8, 0, 0, 8'h11);
    drive(15, 15, 0, 0);
    #2;
    rst = 1'b1;
    void'(sb.pop_front());
    #1;
    n_tests++;
    if (addsub !== 8'h00) begin
      n_fail++;
      $display("FAIL async_clear: got %h expected %h", addsub, 8'h00);
    end
    @(posedge clk); #1;
    n_tests++;
    if (addsub !== 8'h00) begin
      n_fail++;
      $display("FAIL async_discard: got %h expected %h", addsub, 8'h00);
    end
    @(negedge clk);
    rst = 1'b0;
    test_table("post_async", 3, 4, 0, 0, 8'h07);
  endtask

  task automatic test_exhaustive;
    int k;
    int fails_before;
    fails_before = n_fail;
    k = 0;
    for (int co = 0; co < 2; co++)
      for (int ci = 0; ci < 2; ci++)
        for (int av = 0; av < 16; av++)
          for (int bv = 0; bv < 16; bv++) begin
            drive(av, bv, ci, co);
            @(posedge clk); #1;
            exp_v = sb.pop_front();
            n_tests++;
            if (addsub !== exp_v) begin
              n_fail++;
              $display("FAIL sweep a=%0d b=%0d cin=%0d cout=%0d: got %h expected %h",
                       av, bv, ci, co, addsub, exp_v);
            end
            k++;
          end
    $display("[TB] sweep %0d vectors, %0d errors", k, n_fail - fails_before);
  endtask

  initial begin
    n_tests = 0;
    n_fail = 0;
    rst = 1'b1;
    a = '0; b = '0; cin = 1'b0; cout = 1'b0;
    test_reset();
    test_add();
    test_sub();
    test_raw();
    test_back_to_back();
    test_async_reset();
    test_exhaustive();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
